// File: rtl/gray_conv_pkg.sv
// Shared types for the gray/binary conversion scheduler.
// State encoding and request mode constants.
package gray_conv_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid request at or above the pointer,
// wrapping around; one-hot grant plus encoded index.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);
  logic w_found;
  int   w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(i_ptr) + k) % NUM_REQ;
      if (i_en && !w_found && i_req[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = ID_W'(w_j);
        w_found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gray_conv_scheduler.sv
// Shared bin2gray / serial gray2bin engine, round-robin arbitrated
// between NUM_REQ requesters with a tagged valid/ready response.
module gray_conv_scheduler #(
  parameter  int WIDTH   = 4,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_mode,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_ready,
  output logic                     busy
);
  import gray_conv_pkg::*;

  localparam int K_W = $clog2(WIDTH);

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_b;
  logic [K_W-1:0]   r_k;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_en;
  logic             w_acc;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_data;
  logic             w_mode;
  logic [WIDTH-1:0] w_b_next;

  // grants are suppressed while reset is applied
  assign w_en = (r_state == IDLE) && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_acc     = |w_grant;
  assign w_data    = req_data[w_idx*WIDTH +: WIDTH];
  assign w_mode    = req_mode[w_idx];
  assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_b_next      = r_b;
    w_b_next[r_k] = r_b[r_k + 1'b1] ^ r_g[r_k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_k         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_rsp_id <= w_idx;
            r_ptr    <= w_ptr_nxt;
            if (w_mode == MODE_B2G) begin
              r_rsp_data  <= w_data ^ (w_data >> 1);
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_g     <= w_data;
              r_b     <= {w_data[WIDTH-1], {(WIDTH-1){1'b0}}};
              r_k     <= K_W'(WIDTH-2);
              r_state <= CONV;
            end
          end
        end
        CONV: begin
          r_b <= w_b_next;
          r_k <= r_k - 1'b1;
          if (r_k == '0) begin
            r_rsp_data  <= w_b_next;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Scoreboard bench for gray_conv_scheduler: arbitration order,
// latencies, backpressure, mid-op reset and full round trip.
module tb_gray_conv_scheduler;
  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_mode;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_ready;
  logic                     busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ID_W+WIDTH-1:0] sb[$];

  gray_conv_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] m_b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] m_g2b(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request, waits for its response and completes the handshake.
  task automatic do_req(input int id, input logic mode, input logic [3:0] d,
                        output int lat, output logic [1:0] rid,
                        output logic [3:0] rdat, output int busy_lo);
    int w;
    req_mode[id] = mode;
    req_data[id*4 +: 4] = d;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    lat = 99; rid = '0; rdat = '0; busy_lo = 0;
    #1;
    w = 0;
    while (!req_ready[id] && w < 16) begin
      @(negedge clk); #1; w++;
    end
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (busy !== 1'b1) busy_lo++;
      if (rsp_valid === 1'b1) begin
        lat = c; rid = rsp_id; rdat = rsp_data;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1111;
    req_mode = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_data, busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b id=%0d d=%b busy=%b exp all 0",
               rsp_valid, rsp_id, rsp_data, busy);
    end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_b2g();
    int lat, bl; logic [1:0] rid; logic [3:0] rd; logic [5:0] e;
    do_reset();
    sb.push_back({2'd2, m_b2g(4'b1011)});
    do_req(2, 1'b0, 4'b1011, lat, rid, rd, bl);
    e = sb.pop_front();
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL b2g_latency got=%0d exp=1", lat); end
    n_tests++;
    if ({rid, rd} !== e || e !== {2'd2, 4'b1110}) begin
      n_fail++; $display("FAIL b2g_result got id=%0d d=%b exp id=2 d=1110", rid, rd);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2g_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_g2b();
    int lat, bl; logic [1:0] rid; logic [3:0] rd; logic [5:0] e;
    sb.push_back({2'd1, m_g2b(4'b1110)});
    do_req(1, 1'b1, 4'b1110, lat, rid, rd, bl);
    e = sb.pop_front();
    n_tests++;
    if (lat !== 4) begin n_fail++; $display("FAIL g2b_latency got=%0d exp=4", lat); end
    n_tests++;
    if ({rid, rd} !== e) begin
      n_fail++; $display("FAIL g2b_result got id=%0d d=%b exp id=%0d d=%b",
                         rid, rd, e[5:4], e[3:0]);
    end
    n_tests++;
    if (bl !== 0) begin n_fail++; $display("FAIL g2b_busy low cycles got=%0d exp=0", bl); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL g2b_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int grants = 0;
    int gi;
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_mode[i] = 1'b0;
      req_data[i*4 +: 4] = 4'(i*3 + 1);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        gi = 0;
        for (int k = 0; k < 4; k++) if (req_ready[k]) gi = k;
        n_tests++;
        if (!$onehot(req_ready) || gi != order[grants]) begin
          n_fail++; $display("FAIL rr_grant[%0d] got=%b exp idx=%0d", grants, req_ready, order[grants]);
        end
        sb.push_back({2'(gi), m_b2g(4'(gi*3 + 1))});
        grants++;
      end
      if (rsp_valid === 1'b1) begin
        e = sb.pop_front();
        n_tests++;
        if ({rsp_id, rsp_data} !== e) begin
          n_fail++; $display("FAIL rr_rsp got id=%0d d=%b exp id=%0d d=%b",
                             rsp_id, rsp_data, e[5:4], e[3:0]);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if ({rsp_id, rsp_data} !== e) begin
          n_fail++; $display("FAIL rr_rsp_drain got id=%0d d=%b exp id=%0d d=%b",
                             rsp_id, rsp_data, e[5:4], e[3:0]);
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (grants != 6 || sb.size() != 0) begin
      n_fail++; $display("FAIL rr_count got grants=%0d left=%0d exp 6/0", grants, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    logic [5:0] e;
    do_reset();
    rsp_ready = 1'b0;
    req_mode = '0;
    req_data[0 +: 4] = 4'b0110;
    req_data[12 +: 4] = 4'b0011;
    req_valid = 4'b1001;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL bp_first_grant got=%b exp=0001", req_ready);
    end
    sb.push_back({2'd0, m_b2g(4'b0110)});
    @(negedge clk);
    req_valid[0] = 1'b0;
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_data} !== e || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b id=%0d d=%b rdy=%b exp v=1 id=0 d=%b rdy=0000",
                 c, rsp_valid, rsp_id, rsp_data, req_ready, e[3:0]);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1000", rsp_valid, req_ready);
    end
    sb.push_back({2'd3, m_b2g(4'b0011)});
    @(negedge clk);
    req_valid = '0;
    e = sb.pop_front();
    n_tests++;
    if (rsp_valid !== 1'b1 || {rsp_id, rsp_data} !== e) begin
      n_fail++; $display("FAIL bp_second_rsp got v=%b id=%0d d=%b exp v=1 id=3 d=%b",
                         rsp_valid, rsp_id, rsp_data, e[3:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    int seen = 0;
    do_reset();
    req_mode[2] = 1'b1;
    req_data[8 +: 4] = 4'b1110;
    req_valid = 4'b0100;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL rm_grant got=%b exp=0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_data, busy, req_ready} !== 12'h000) begin
      n_fail++;
      $display("FAIL rm_after_reset got v=%b id=%0d d=%b busy=%b rdy=%b exp all 0",
               rsp_valid, rsp_id, rsp_data, busy, req_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rm_no_rsp got=%0d valid cycles exp=0", seen); end
    req_mode = '0;
    req_data[4 +: 4] = 4'b0100;
    req_data[12 +: 4] = 4'b1111;
    req_valid = 4'b1010;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rm_ptr_zero got=%b exp=0010", req_ready);
    end
    sb.push_back({2'd1, m_b2g(4'b0100)});
    @(negedge clk);
    req_valid = '0;
    e = sb.pop_front();
    n_tests++;
    if (rsp_valid !== 1'b1 || {rsp_id, rsp_data} !== e) begin
      n_fail++; $display("FAIL rm_new_rsp got v=%b id=%0d d=%b exp v=1 id=1 d=%b",
                         rsp_valid, rsp_id, rsp_data, e[3:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    int lat, bl, good;
    logic [1:0] rid; logic [3:0] rd, g; logic [5:0] e;
    good = 0;
    do_reset();
    for (int v = 0; v < 16; v++) begin
      sb.push_back({2'(v % 4), m_b2g(4'(v))});
      do_req(v % 4, 1'b0, 4'(v), lat, rid, rd, bl);
      e = sb.pop_front();
      g = rd;
      n_tests++;
      if ({rid, rd} !== e || lat !== 1) begin
        n_fail++; $display("FAIL rt_b2g[%0d] got id=%0d d=%b lat=%0d exp id=%0d d=%b lat=1",
                           v, rid, rd, lat, e[5:4], e[3:0]);
      end
      sb.push_back({2'(v % 4), 4'(v)});
      do_req(v % 4, 1'b1, g, lat, rid, rd, bl);
      e = sb.pop_front();
      n_tests++;
      if ({rid, rd} !== e || lat !== 4) begin
        n_fail++; $display("FAIL rt_g2b[%0d] got id=%0d d=%b lat=%0d exp id=%0d d=%b lat=4",
                           v, rid, rd, lat, e[5:4], e[3:0]);
      end else good++;
    end
    n_tests++;
    if (good != 16) begin n_fail++; $display("FAIL rt_total got=%0d exp=16", good); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_mode = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_b2g();
    test_g2b();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
